// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM port: requester 0 has fixed priority, the rest rotate round-robin.
// Latency: response registered two edges after acceptance, one read per clock, in acceptance order.
// Backpressure: none on the response path; req_ready depends only on req_valid and the RR pointer.
module sprite_rom_arbiter #(
    parameter int             NREQ   = 4,
    parameter int             DEPTH  = 76800,
    parameter int             AW     = 20,
    parameter int             DW     = 12,
    parameter logic [DW-1:0]  TRANSP = 12'hF0F
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*AW-1:0]  req_addr,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [DW-1:0]       rsp_data,
    output logic                rsp_err,
    output logic [AW-1:0]       rom_addr,
    input  logic [DW-1:0]       rom_data
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NS  = NREQ - 1;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
        logic           err;
    } stage_t;

    logic [IDW-1:0] rr_ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0] grant_idx;
    logic           grant_vld;
    logic           found;
    logic [AW-1:0]  acc_addr;
    stage_t         s1, s2;

    // Video fetch wins outright; otherwise scan engines 1..NREQ-1 starting at rr_ptr.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (Reset_n) begin
            if (req_valid[0]) begin
                grant[0] = 1'b1;
                found    = 1'b1;
            end else begin
                for (int o = 0; o < NS; o++) begin
                    if (!found && req_valid[((int'(rr_ptr) - 1 + o) % NS) + 1]) begin
                        found     = 1'b1;
                        grant_idx = IDW'(((int'(rr_ptr) - 1 + o) % NS) + 1);
                        grant[((int'(rr_ptr) - 1 + o) % NS) + 1] = 1'b1;
                    end
                end
            end
        end
    end

    assign grant_vld = found;
    assign req_ready = grant;

    always_comb begin
        acc_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) acc_addr = req_addr[i*AW +: AW];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr <= IDW'(1);
        end else if (grant_vld && grant_idx != '0) begin
            rr_ptr <= (int'(grant_idx) == NS) ? IDW'(1) : grant_idx + 1'b1;
        end
    end

    // Out-of-range reads still drive the ROM; the flag overrides the data at the output.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            s1       <= '0;
            s2       <= '0;
        end else begin
            s1.vld <= grant_vld;
            s1.id  <= grant_idx;
            s1.err <= ({1'b0, acc_addr} >= (AW+1)'(DEPTH));
            if (grant_vld) rom_addr <= acc_addr;
            s2 <= s1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= s2.vld ? (NREQ'(1) << s2.id) : '0;
            rsp_err   <= s2.vld & s2.err;
            if (s2.vld) rsp_data <= s2.err ? TRANSP : rom_data;
        end
    end

endmodule
